// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous data-RAM port between the core (cpu)
// and the UART debug controller (dbg). The cpu has fixed priority, but dbg is
// guaranteed the port after MAX_HOLD consecutive cpu grants while it waits.
// Read data returns one cycle after the grant, straight from the RAM output.
module data_mem_arbiter #(
  parameter int WORD_SIZE  = 18,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_HOLD   = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  // core requester
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [WORD_SIZE-1:0]  cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [WORD_SIZE-1:0]  cpu_rdata,
  // debug requester
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [WORD_SIZE-1:0]  dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [WORD_SIZE-1:0]  dbg_rdata,
  // RAM port
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WORD_SIZE-1:0]  mem_write,
  output logic                  mem_wren,
  input  logic [WORD_SIZE-1:0]  mem_read
);

  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [7:0]            hold_cnt_q, hold_cnt_d;
  logic                  rd_cpu_q, rd_cpu_d;
  logic                  rd_dbg_q, rd_dbg_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  cpu_gnt_s, dbg_gnt_s;

  // Grant decision: cpu first unless dbg has waited through MAX_HOLD cpu grants.
  always_comb begin
    cpu_gnt_s = 1'b0;
    dbg_gnt_s = 1'b0;
    if (!reset_n) begin
      cpu_gnt_s = 1'b0;
      dbg_gnt_s = 1'b0;
    end else if (cpu_req && dbg_req) begin
      if (hold_cnt_q >= MAX_HOLD_C) begin
        dbg_gnt_s = 1'b1;
      end else begin
        cpu_gnt_s = 1'b1;
      end
    end else if (cpu_req) begin
      cpu_gnt_s = 1'b1;
    end else if (dbg_req) begin
      dbg_gnt_s = 1'b1;
    end else begin
      cpu_gnt_s = 1'b0;
      dbg_gnt_s = 1'b0;
    end
  end

  // Starvation counter: counts cpu wins while dbg waits, cleared once dbg is served or gives up.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (dbg_gnt_s || !dbg_req) begin
      hold_cnt_d = 8'd0;
    end else if (cpu_gnt_s) begin
      if (hold_cnt_q < MAX_HOLD_C) begin
        hold_cnt_d = hold_cnt_q + 8'd1;
      end else begin
        hold_cnt_d = MAX_HOLD_C;
      end
    end else begin
      hold_cnt_d = hold_cnt_q;
    end
  end

  // RAM mux: the granted requester drives the port; idle cycles keep the last address stable.
  always_comb begin
    mem_address = last_addr_q;
    mem_write   = cpu_wdata;
    if (dbg_gnt_s) begin
      mem_address = dbg_addr;
      mem_write   = dbg_wdata;
    end else if (cpu_gnt_s) begin
      mem_address = cpu_addr;
      mem_write   = cpu_wdata;
    end else begin
      mem_address = last_addr_q;
      mem_write   = cpu_wdata;
    end
    mem_wren    = (cpu_gnt_s & cpu_we) | (dbg_gnt_s & dbg_we);
    last_addr_d = mem_address;
    rd_cpu_d    = cpu_gnt_s & ~cpu_we;
    rd_dbg_d    = dbg_gnt_s & ~dbg_we;
  end

  // State flops; reset drops any read still in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q  <= 8'd0;
      rd_cpu_q    <= 1'b0;
      rd_dbg_q    <= 1'b0;
      last_addr_q <= '0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      rd_cpu_q    <= rd_cpu_d;
      rd_dbg_q    <= rd_dbg_d;
      last_addr_q <= last_addr_d;
    end
  end

  assign cpu_gnt    = cpu_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign cpu_rvalid = rd_cpu_q;
  assign dbg_rvalid = rd_dbg_q;
  assign cpu_rdata  = mem_read;
  assign dbg_rdata  = mem_read;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a write-first RAM model plus directed scenarios
// and a randomized run checked against a simple behavioural model.
module tb_data_mem_arbiter;

  localparam int W  = 18;
  localparam int A  = 16;
  localparam int MH = 4;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [A-1:0] cpu_addr = '0;
  logic [W-1:0] cpu_wdata = '0;
  logic         cpu_gnt, cpu_rvalid;
  logic [W-1:0] cpu_rdata;
  logic         dbg_req = 1'b0, dbg_we = 1'b0;
  logic [A-1:0] dbg_addr = '0;
  logic [W-1:0] dbg_wdata = '0;
  logic         dbg_gnt, dbg_rvalid;
  logic [W-1:0] dbg_rdata;
  logic [A-1:0] mem_address;
  logic [W-1:0] mem_write;
  logic         mem_wren;
  logic [W-1:0] mem_read;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] ram [0:255];

  data_mem_arbiter #(.WORD_SIZE(W), .ADDR_WIDTH(A), .MAX_HOLD(MH)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_address(mem_address), .mem_write(mem_write), .mem_wren(mem_wren),
    .mem_read(mem_read)
  );

  always #5 clock = ~clock;

  // Synchronous write-first RAM, 1-cycle read latency
  always @(posedge clock) begin
    if (mem_wren) ram[mem_address[7:0]] <= mem_write;
    mem_read <= mem_wren ? mem_write : ram[mem_address[7:0]];
  end

  task automatic drive(input logic cr, input logic cw, input logic [A-1:0] ca, input logic [W-1:0] cd,
                       input logic dr, input logic dw, input logic [A-1:0] da, input logic [W-1:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 18'h0, 1'b0, 1'b0, 16'h0, 18'h0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 16'h5, 18'h1, 1'b1, 1'b1, 16'h6, 18'h2);
    repeat (2) @(negedge clock);
    #1;
    total++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt: cpu=%b dbg=%b want 0 0", cpu_gnt, dbg_gnt); end
    total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
    total++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: cpu=%b dbg=%b want 0 0", cpu_rvalid, dbg_rvalid); end
    total++; if (mem_address !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", mem_address); end
    idle();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_dbg_write_read();
    drive(1'b0, 1'b0, 16'h0, 18'h0, 1'b1, 1'b1, 16'h0010, 18'h2ABCD);
    #1;
    total++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin bad++; $display("FAIL dbgwr_gnt: dbg=%b cpu=%b want 1 0", dbg_gnt, cpu_gnt); end
    total++; if (mem_wren !== 1'b1 || mem_address !== 16'h0010 || mem_write !== 18'h2ABCD) begin
      bad++; $display("FAIL dbgwr_port: wren=%b addr=%h data=%h want 1 0010 2abcd", mem_wren, mem_address, mem_write); end
    @(negedge clock);
    drive(1'b0, 1'b0, 16'h0, 18'h0, 1'b1, 1'b0, 16'h0010, 18'h0);
    #1;
    total++; if (dbg_gnt !== 1'b1 || mem_wren !== 1'b0) begin bad++; $display("FAIL dbgrd_gnt: gnt=%b wren=%b want 1 0", dbg_gnt, mem_wren); end
    @(posedge clock); #1;
    total++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 18'h2ABCD) begin bad++; $display("FAIL dbgrd_data: rvalid=%b data=%h want 1 2abcd", dbg_rvalid, dbg_rdata); end
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL dbgrd_cpuvalid: got %b want 0", cpu_rvalid); end
    @(negedge clock);
    idle();
    @(posedge clock); #1;
    total++; if (dbg_rvalid !== 1'b0) begin bad++; $display("FAIL dbgrd_once: got %b want 0", dbg_rvalid); end
    @(negedge clock);
  endtask

  task automatic test_fairness();
    drive(1'b1, 1'b0, 16'h0020, 18'h0, 1'b1, 1'b0, 16'h0021, 18'h0);
    for (int i = 0; i < 10; i++) begin
      logic exp_dbg;
      exp_dbg = ((i % 5) == 4);
      #1;
      total++; if (cpu_gnt !== ~exp_dbg || dbg_gnt !== exp_dbg) begin
        bad++; $display("FAIL fairness_c%0d: cpu=%b dbg=%b want %b %b", i, cpu_gnt, dbg_gnt, ~exp_dbg, exp_dbg); end
      @(negedge clock);
    end
    idle();
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, A'(k), W'(18'h100 + k), 1'b0, 1'b0, 16'h0, 18'h0);
      #1;
      total++; if (cpu_gnt !== 1'b1 || mem_wren !== 1'b1) begin bad++; $display("FAIL b2b_wr%0d: gnt=%b wren=%b want 1 1", k, cpu_gnt, mem_wren); end
      @(negedge clock);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b0, A'(k), 18'h0, 1'b0, 1'b0, 16'h0, 18'h0);
      @(posedge clock); #1;
      total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== W'(18'h100 + k)) begin
        bad++; $display("FAIL b2b_rd%0d: rvalid=%b data=%h want 1 %h", k, cpu_rvalid, cpu_rdata, W'(18'h100 + k)); end
      @(negedge clock);
    end
    idle();
    @(posedge clock); #1;
    total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_end: rvalid=%b want 0", cpu_rvalid); end
    @(negedge clock);
  endtask

  task automatic test_write_then_read();
    drive(1'b1, 1'b1, 16'h0007, 18'h00005, 1'b0, 1'b0, 16'h0, 18'h0);
    #1;
    total++; if (mem_wren !== 1'b1 || mem_address !== 16'h0007) begin bad++; $display("FAIL wtr_wr: wren=%b addr=%h want 1 0007", mem_wren, mem_address); end
    @(negedge clock);
    drive(1'b0, 1'b0, 16'h0, 18'h0, 1'b1, 1'b0, 16'h0007, 18'h0);
    @(posedge clock); #1;
    total++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 18'h00005 || cpu_rvalid !== 1'b0) begin
      bad++; $display("FAIL wtr_rd: dvalid=%b data=%h cvalid=%b want 1 00005 0", dbg_rvalid, dbg_rdata, cpu_rvalid); end
    @(negedge clock);
    idle();
    @(negedge clock);
  endtask

  task automatic test_withdraw();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, A'(16'h30 + i), W'(i), (i < 2), 1'b1, 16'h0040, 18'h3FFFF);
      #1;
      total++; if (dbg_gnt !== 1'b0 || cpu_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_address !== A'(16'h30 + i) || mem_write !== W'(i)) begin
        bad++; $display("FAIL withdraw_c%0d: dgnt=%b cgnt=%b wren=%b addr=%h data=%h want 0 1 1 %h %h",
                        i, dbg_gnt, cpu_gnt, mem_wren, mem_address, mem_write, A'(16'h30 + i), W'(i)); end
      @(negedge clock);
    end
    idle();
    #1;
    total++; if (mem_address !== 16'h0033 || mem_wren !== 1'b0 || cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0) begin
      bad++; $display("FAIL idle_hold: addr=%h wren=%b gnt=%b%b want 0033 0 00", mem_address, mem_wren, cpu_gnt, dbg_gnt); end
    @(negedge clock);
    drive(1'b1, 1'b0, 16'h0030, 18'h0, 1'b1, 1'b0, 16'h0031, 18'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (dbg_gnt !== (i == 4) || cpu_gnt !== (i != 4)) begin
        bad++; $display("FAIL withdraw_hold_c%0d: cpu=%b dbg=%b want %b %b", i, cpu_gnt, dbg_gnt, (i != 4), (i == 4)); end
      @(negedge clock);
    end
    idle();
    @(negedge clock);
  endtask

  task automatic test_reset_mid_read();
    drive(1'b1, 1'b0, 16'h0001, 18'h0, 1'b0, 1'b0, 16'h0, 18'h0);
    #1;
    total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL rmr_gnt: got %b want 1", cpu_gnt); end
    @(posedge clock); #1;
    idle();
    reset_n = 1'b0;
    #1;
    total++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_drop: cpu=%b dbg=%b want 0 0", cpu_rvalid, dbg_rvalid); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (cpu_gnt !== 1'b0 || dbg_gnt !== 1'b0 || mem_wren !== 1'b0 || mem_address !== 16'h0) begin
        bad++; $display("FAIL rmr_idle%0d: gnt=%b%b wren=%b addr=%h want 00 0 0000", i, cpu_gnt, dbg_gnt, mem_wren, mem_address); end
      @(posedge clock); #1;
      total++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin bad++; $display("FAIL rmr_spurious%0d: cpu=%b dbg=%b want 0 0", i, cpu_rvalid, dbg_rvalid); end
      @(negedge clock);
    end
    drive(1'b1, 1'b0, 16'h0002, 18'h0, 1'b0, 1'b0, 16'h0, 18'h0);
    @(posedge clock); #1;
    total++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 18'h102) begin bad++; $display("FAIL rmr_resume: rvalid=%b data=%h want 1 00102", cpu_rvalid, cpu_rdata); end
    @(negedge clock);
    idle();
    @(negedge clock);
  endtask

  task automatic test_random();
    logic [W-1:0] shadow [0:15];
    int           streak;
    logic [A-1:0] last_a;
    logic         cr, cw, dr, dw, c_won, d_won;
    logic [A-1:0] ca, da;
    logic [W-1:0] cd, dd;
    // preload a small address window through cpu writes
    for (int k = 0; k < 16; k++) begin
      shadow[k] = W'($urandom);
      drive(1'b1, 1'b1, A'(k), shadow[k], 1'b0, 1'b0, 16'h0, 18'h0);
      #1;
      total++; if (cpu_gnt !== 1'b1 || mem_wren !== 1'b1) begin bad++; $display("FAIL rnd_init%0d: gnt=%b wren=%b want 1 1", k, cpu_gnt, mem_wren); end
      @(negedge clock);
    end
    streak = 0; last_a = 16'd15;
    cr = 1'b0; dr = 1'b0; c_won = 1'b0; d_won = 1'b0;
    cw = 1'b0; dw = 1'b0; ca = '0; da = '0; cd = '0; dd = '0;
    for (int n = 0; n < 400; n++) begin
      logic ec, ed, ewren, erc, erd;
      logic [A-1:0] eaddr;
      logic [W-1:0] ewdata, erdata;
      // requesters keep an ungranted request stable, occasionally withdrawing it
      if (cr && !c_won) begin
        if ($urandom_range(0, 7) == 0) cr = 1'b0;
      end else begin
        cr = ($urandom_range(0, 99) < 65); cw = $urandom_range(0, 1) == 1;
        ca = A'($urandom_range(0, 15)); cd = W'($urandom);
      end
      if (dr && !d_won) begin
        if ($urandom_range(0, 7) == 0) dr = 1'b0;
      end else begin
        dr = ($urandom_range(0, 99) < 50); dw = $urandom_range(0, 1) == 1;
        da = A'($urandom_range(0, 15)); dd = W'($urandom);
      end
      drive(cr, cw, ca, cd, dr, dw, da, dd);
      // reference: cpu wins unless dbg has already waited through MH cpu grants
      ec = cr && (!dr || streak < MH);
      ed = dr && !ec;
      ewren  = (ec && cw) || (ed && dw);
      eaddr  = ec ? ca : (ed ? da : last_a);
      ewdata = ec ? cd : dd;
      #1;
      total++; if (cpu_gnt !== ec || dbg_gnt !== ed || mem_wren !== ewren || mem_address !== eaddr) begin
        bad++; $display("FAIL rnd_port%0d: gnt=%b%b wren=%b addr=%h want %b%b %b %h", n, cpu_gnt, dbg_gnt, mem_wren, mem_address, ec, ed, ewren, eaddr); end
      if (ewren) begin
        total++; if (mem_write !== ewdata) begin bad++; $display("FAIL rnd_wdata%0d: got %h want %h", n, mem_write, ewdata); end
      end
      if (ed || !dr) streak = 0;
      else if (ec && streak < MH) streak++;
      last_a = eaddr;
      if (ewren) shadow[eaddr[3:0]] = ewdata;
      erc = ec && !cw; erd = ed && !dw;
      erdata = shadow[eaddr[3:0]];
      c_won = ec; d_won = ed;
      @(posedge clock); #1;
      total++; if (cpu_rvalid !== erc || dbg_rvalid !== erd) begin
        bad++; $display("FAIL rnd_rvalid%0d: cpu=%b dbg=%b want %b %b", n, cpu_rvalid, dbg_rvalid, erc, erd); end
      if (erc || erd) begin
        total++; if ((erc && cpu_rdata !== erdata) || (erd && dbg_rdata !== erdata)) begin
          bad++; $display("FAIL rnd_rdata%0d: cpu=%h dbg=%h want %h", n, cpu_rdata, dbg_rdata, erdata); end
      end
      @(negedge clock);
    end
    idle();
    @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_dbg_write_read();
    test_fairness();
    test_back_to_back();
    test_write_then_read();
    test_withdraw();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single data-memory port (synchronous RAM, 1-cycle read latency) between two requesters: the processor core (cpu) and the UART debug controller (dbg).
- Arbitration uses fixed priority with anti-starvation: cpu normally wins; dbg is guaranteed a slot after MAX_HOLD consecutive cpu grants while dbg waits.
- Sits between the core, the UART debug controller and the data RAM instance, so memory can be accessed over UART while the core runs.

Parameters:
- WORD_SIZE, 18, data word width.
- ADDR_WIDTH, 16, memory address width.
- MAX_HOLD, 4, max consecutive cpu grants while dbg is pending (range 1..255).

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous reset, active-low.
- cpu_req  in  1  cpu requests one access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_WIDTH  cpu address.
- cpu_wdata  in  WORD_SIZE  cpu write data.
- cpu_gnt  out  1  access accepted this cycle (combinational).
- cpu_rvalid  out  1  cpu read data valid (registered).
- cpu_rdata  out  WORD_SIZE  read data; meaningful only while cpu_rvalid=1.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as the cpu_* ports, for the debug requester.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_write  out  WORD_SIZE  RAM write data.
- mem_wren  out  1  RAM write enable.
- mem_read  in  WORD_SIZE  RAM q; valid 1 cycle after the address is presented.

Behaviour:
- Grant is combinational from the req inputs and the registered hold_cnt. At most one gnt per cycle. An access completes in the cycle its gnt=1.
- Handshake: a requester holds req, we, addr and wdata stable until it sees gnt=1. Deasserting req before gnt is allowed and means the request is withdrawn; no access occurs.
- Decision rules:
  - Only cpu_req: cpu_gnt=1.
  - Only dbg_req: dbg_gnt=1.
  - Both, hold_cnt < MAX_HOLD: cpu_gnt=1.
  - Both, hold_cnt == MAX_HOLD: dbg_gnt=1.
  - Neither: no grant.
- hold_cnt (width 8) updates on posedge:
  - Cleared when dbg_gnt=1 or dbg_req=0.
  - Incremented when cpu_gnt=1 and dbg_req=1; saturates at MAX_HOLD.
- Memory mux:
  - mem_address = granted requester's addr; when idle, it holds the last granted address (no glitching to 0).
  - mem_write = granted requester's wdata.
  - mem_wren = (cpu_gnt & cpu_we) | (dbg_gnt & dbg_we).
- Read return:
  - Registered flags rd_cpu and rd_dbg are set to (gnt & ~we) of the respective requester, one cycle later.
  - cpu_rvalid = rd_cpu, dbg_rvalid = rd_dbg. Both rdata outputs are driven directly from mem_read.
  - Read latency is exactly 1 cycle from gnt to rvalid. Back-to-back reads are allowed every cycle.
  - Reads and writes are never reordered. A read granted the cycle after a write to the same address returns the new data (RAM is in write-first mode).
- Reset, asserted asynchronously:
  - hold_cnt=0, rd_cpu=rd_dbg=0, last address register=0.
  - cpu_gnt, dbg_gnt and mem_wren are forced to 0 while reset_n=0.
- Reset mid-read: the pending rvalid is dropped and is not reissued after reset.
- Simultaneous write by the granted requester and request by the other: only the granted write reaches RAM. The other requester waits; its data is not lost because it keeps req asserted.

Test Plan:
- After reset, dbg write addr 0x0010 data 0x2ABCD with cpu idle -> dbg_gnt=1 same cycle, mem_wren=1, mem_address=0x0010. Then dbg read 0x0010 -> dbg_rvalid 1 cycle later, dbg_rdata=0x2ABCD, cpu_rvalid stays 0.
- cpu and dbg both hold req continuously, MAX_HOLD=4 -> grant pattern cpu,cpu,cpu,cpu,dbg,cpu,cpu,cpu,cpu,dbg...; never two gnts in the same cycle.
- cpu reads addr 1,2,3 on consecutive cycles -> cpu_rvalid high for 3 consecutive cycles starting 1 cycle after the first gnt, data in order.
- cpu write 0x00005 to addr 7, then dbg read addr 7 the next cycle -> dbg_rdata=0x00005.
- dbg_req asserted 2 cycles then withdrawn while cpu holds the port -> no dbg access, mem_wren only for cpu writes, hold_cnt returns to 0.
- reset_n pulled low the cycle after a granted read -> cpu_rvalid=0 immediately; after release, no spurious rvalid and all gnt=0 until a new req arrives.
